// File: rtl/db15_pkg.sv
// Shared constants and state type for the DB15 joystick serial transmitter.
// Imported by db15_sync and db15_joy_tx.
package db15_pkg;
  localparam int FRAME_BITS  = 32;
  localparam int PLAYER_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } db15_state_t;
endpackage

// File: rtl/db15_sync.sv
// Multi-flop synchronizer for one asynchronous line.
// Also provides rise/fall pulses; flops reset to the idle-high level.
module db15_sync
  import db15_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/db15_joy_tx.sv
// DB15 joystick serial transmitter: parallel-load, shift out both players.
// Define DB15_JOY_TX_WATCHDOG_EN to add the load-pulse link watchdog.
module db15_joy_tx
  import db15_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WD_CYCLES   = 4000000
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        joy_clk_i,
  input  logic        joy_load_i,
  output logic        joy_data_o,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  output logic [5:0]  bit_count,
  output logic        frame_done,
  output logic        link_active
);

  logic w_clk_lvl;
  logic w_clk_rise;
  logic w_clk_fall;
  logic w_load_lvl;
  logic w_load_rise;
  logic w_load_fall;
  logic w_data;
  logic w_unused;

  db15_state_t r_state;
  db15_state_t w_next;

  logic [FRAME_BITS-1:0] r_shift;
  logic [5:0]            r_count;
  logic                  r_fd;

  db15_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .i_async (joy_clk_i),
    .o_level (w_clk_lvl),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  db15_sync #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .i_async (joy_load_i),
    .o_level (w_load_lvl),
    .o_rise  (w_load_rise),
    .o_fall  (w_load_fall)
  );

  always_ff @(posedge clk_sys) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!w_load_lvl) begin
      w_next = LOAD;
    end else begin
      case (r_state)
        LOAD:
          if (w_load_rise) w_next = SHIFT;
        SHIFT:
          if (w_clk_rise && r_count == 6'(FRAME_BITS-1))
            w_next = DONE;
        default:
          w_next = r_state;
      endcase
    end
  end

  // Load low dominates: capture every cycle, clock edges ignored.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_shift <= '1;
      r_count <= '0;
      r_fd    <= 1'b0;
    end else begin
      r_fd <= 1'b0;
      if (!w_load_lvl) begin
        r_shift <= ~{joystick1, joystick2};
        r_count <= '0;
      end else if (r_state == SHIFT && w_clk_rise) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], 1'b1};
        r_count <= r_count + 6'd1;
        if (r_count == 6'(FRAME_BITS-1)) r_fd <= 1'b1;
      end
    end
  end

  assign w_data     = (r_state == LOAD) ? ~joystick1[PLAYER_BITS-1]
                                        : r_shift[FRAME_BITS-1];
  assign bit_count  = r_count;
  assign frame_done = r_fd;

`ifdef DB15_JOY_TX_WATCHDOG_EN
  localparam int WDW = $clog2(WD_CYCLES + 1);

  logic [WDW-1:0] r_wd;
  logic           r_seen;
  logic           w_alive;

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_wd   <= '0;
      r_seen <= 1'b0;
    end else if (w_load_fall) begin
      r_wd   <= '0;
      r_seen <= 1'b1;
    end else if (r_wd < WDW'(WD_CYCLES)) begin
      r_wd <= r_wd + WDW'(1);
    end
  end

  assign w_alive     = r_seen && (r_wd < WDW'(WD_CYCLES));
  assign link_active = w_alive;
  assign joy_data_o  = w_alive ? w_data : 1'b1;
  assign w_unused    = ^{w_clk_lvl, w_clk_fall};
`else
  assign link_active = 1'b1;
  assign joy_data_o  = w_data;
  assign w_unused    = ^{w_clk_lvl, w_clk_fall, w_load_fall,
                         (WD_CYCLES != 0)};
`endif

endmodule

// File: tb/tb_db15_joy_tx.sv
// Directed scoreboard bench for db15_joy_tx.
// Define DB15_JOY_TX_WATCHDOG_EN to also exercise the link watchdog.
module tb_db15_joy_tx;
  localparam int SS = 2;
  localparam int WD = 2000;

  logic        clk_sys    = 1'b0;
  logic        RESET      = 1'b1;
  logic        joy_clk_i  = 1'b0;
  logic        joy_load_i = 1'b1;
  logic [15:0] joystick1  = '0;
  logic [15:0] joystick2  = '0;
  logic        joy_data_o;
  logic [5:0]  bit_count;
  logic        frame_done;
  logic        link_active;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   fd_cnt = 0;
  int   f0;
  logic q[$];

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys)
    if (frame_done === 1'b1) fd_cnt++;

  db15_joy_tx #(
    .SYNC_STAGES (SS),
    .WD_CYCLES   (WD)
  ) dut (
    .clk_sys     (clk_sys),
    .RESET       (RESET),
    .joy_clk_i   (joy_clk_i),
    .joy_load_i  (joy_load_i),
    .joy_data_o  (joy_data_o),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .bit_count   (bit_count),
    .frame_done  (frame_done),
    .link_active (link_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Scoreboard: expected serial stream is pushed as load is released.
  task automatic load_pulse();
    logic [31:0] f;
    joy_load_i = 1'b0;
    cyc(6);
    f = ~{joystick1, joystick2};
    q.delete();
    for (int i = 31; i >= 0; i--) q.push_back(f[i]);
    joy_load_i = 1'b1;
    cyc(6);
  endtask

  task automatic jclk();
    joy_clk_i = 1'b1;
    cyc(5);
    joy_clk_i = 1'b0;
    cyc(4);
  endtask

  task automatic shift_n(input string tag, input int n);
    logic e;
    int   c;
    for (int k = 0; k < n; k++) begin
      e = (q.size() > 0) ? q.pop_front() : 1'b1;
      chk($sformatf("%s_bit%0d", tag, k), 32'(joy_data_o), 32'(e));
      jclk();
      c = (k + 1 > 32) ? 32 : k + 1;
      chk($sformatf("%s_cnt%0d", tag, k), 32'(bit_count), 32'(c));
    end
  endtask

  initial begin
    cyc(3);
    chk("rst_data", 32'(joy_data_o), 32'd1);
    chk("rst_cnt", 32'(bit_count), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    RESET = 1'b0;
    cyc(2);
`ifdef DB15_JOY_TX_WATCHDOG_EN
    chk("rst_link", 32'(link_active), 32'd0);
`else
    chk("rst_link", 32'(link_active), 32'd1);
`endif

    // Basic frame, bit order and frame_done
    joystick1 = 16'h0001;
    joystick2 = 16'h8000;
    load_pulse();
    chk("f1_link", 32'(link_active), 32'd1);
    f0 = fd_cnt;
    shift_n("f1", 32);
    cyc(3);
    chk("f1_fd", 32'(fd_cnt - f0), 32'd1);
    chk("f1_tail", 32'(joy_data_o), 32'd1);
    chk("f1_cnt", 32'(bit_count), 32'd32);

    // Overclocking past 32: saturate, ones, single pulse
    joystick1 = 16'hA5C3;
    joystick2 = 16'h3C5A;
    load_pulse();
    f0 = fd_cnt;
    shift_n("f2", 40);
    chk("f2_fd", 32'(fd_cnt - f0), 32'd1);

    // Inputs change after load release: old value shifts
    joystick1 = 16'h0000;
    joystick2 = 16'h1234;
    load_pulse();
    joystick1 = 16'hFFFF;
    shift_n("f3", 32);

    // Abort after 10 edges
    joystick1 = 16'h4001;
    joystick2 = 16'hF00F;
    load_pulse();
    shift_n("f4a", 10);
    f0 = fd_cnt;
    joystick1 = 16'h8000;
    joystick2 = 16'h00FF;
    load_pulse();
    chk("f4_cnt0", 32'(bit_count), 32'd0);
    chk("f4_nofd", 32'(fd_cnt - f0), 32'd0);
    shift_n("f4b", 32);

    // Clock edge while load held low is ignored
    joystick1 = 16'hC3A5;
    joystick2 = 16'h5A3C;
    joy_load_i = 1'b0;
    cyc(4);
    jclk();
    chk("f5_cnt", 32'(bit_count), 32'd0);
    chk("f5_ld", 32'(joy_data_o), 32'd0);
    load_pulse();
    shift_n("f5", 32);

    // Reset mid-frame
    joystick1 = 16'h0F0F;
    joystick2 = 16'h00F0;
    load_pulse();
    shift_n("f6", 16);
    f0 = fd_cnt;
    RESET = 1'b1;
    cyc(1);
    chk("f6_rdata", 32'(joy_data_o), 32'd1);
    chk("f6_rcnt", 32'(bit_count), 32'd0);
    chk("f6_rfd", 32'(frame_done), 32'd0);
    RESET = 1'b0;
    cyc(2);
    for (int i = 0; i < 3; i++) begin
      jclk();
      chk($sformatf("f6_pd%0d", i), 32'(joy_data_o), 32'd1);
      chk($sformatf("f6_pc%0d", i), 32'(bit_count), 32'd0);
    end
    chk("f6_nofd", 32'(fd_cnt - f0), 32'd0);
    joystick1 = 16'h1357;
    joystick2 = 16'h9BDF;
    load_pulse();
    shift_n("f7", 32);

`ifdef DB15_JOY_TX_WATCHDOG_EN
    joystick1 = 16'h8000;
    load_pulse();
    chk("wd_up", 32'(link_active), 32'd1);
    chk("wd_d0", 32'(joy_data_o), 32'd0);
    cyc(WD + 10);
    chk("wd_dead", 32'(link_active), 32'd0);
    chk("wd_d1", 32'(joy_data_o), 32'd1);
    joy_load_i = 1'b0;
    cyc(SS + 2);
    chk("wd_back", 32'(link_active), 32'd1);
    joy_load_i = 1'b1;
    cyc(6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/db15_joy_tx.md
DB15_JOY_TX -- requirements
Module: db15_joy_tx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for joy_clk_i/joy_load_i (legal 2..4).
REQ-002 SHALL have parameter WD_CYCLES, default 4000000, meaning clk_sys cycles without a load pulse before link is declared dead (100 ms at 40 MHz).
REQ-003 SHALL have port clk_sys  input  1  system clock (40 MHz); all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port joy_clk_i  input  1  serial shift clock from the DB15 reader, asynchronous.
REQ-006 SHALL have port joy_load_i  input  1  parallel-load strobe from the reader, asynchronous, active-low.
REQ-007 SHALL have port joy_data_o  output  1  serial data to the reader, active-low button encoding.
REQ-008 SHALL have port joystick1  input  16  player-1 button vector, active-high, bit 0 = right.
REQ-009 SHALL have port joystick2  input  16  player-2 button vector, same layout.
REQ-010 SHALL have port bit_count  output  6  number of bits shifted out since last load, 0..32.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when bit 32 has been shifted.
REQ-012 SHALL have port link_active  output  1  high while the reader is issuing load pulses.

Function
REQ-013 SHALL synchronize joy_clk_i and joy_load_i through SYNC_STAGES flops, then detect rising edge of clk and falling/rising edges of load on synchronized values.
REQ-014 SHALL implement states IDLE, LOAD, SHIFT, DONE; IDLE after reset; any cycle with synchronized load low -> LOAD from every state.
REQ-015 In LOAD, SHALL continuously capture shift register = {~joystick1, ~joystick2} (32 bits) and hold bit_count = 0; joy_data_o = ~joystick1[15].
REQ-016 On synchronized load rising edge, SHALL go LOAD -> SHIFT with the last captured value; inputs changing afterwards SHALL not affect the current frame.
REQ-017 In SHIFT, on each synchronized joy_clk rising edge, SHALL shift left by one, fill LSB with 1, increment bit_count; joy_data_o = register MSB, valid within SYNC_STAGES+1 clk_sys cycles of the edge.
REQ-018 Bit order SHALL be joystick1[15]..joystick1[0], then joystick2[15]..joystick2[0].
REQ-019 When bit_count reaches 32, SHALL pulse frame_done for exactly one cycle and enter DONE.
REQ-020 In DONE and IDLE, joy_clk edges SHALL keep joy_data_o = 1 and bit_count saturated (32 in DONE, 0 in IDLE); no wrap-around.
REQ-021 joy_clk edge while load low, or coincident with load rising edge in the same cycle, SHALL be ignored (load dominates).
REQ-022 Load falling edge mid-frame (SHIFT) SHALL abort the frame: no frame_done, bit_count -> 0, re-enter LOAD.

Reset
REQ-023 On RESET, SHALL set state IDLE, shift register all ones, joy_data_o = 1, bit_count = 0, frame_done = 0, synchronizer flops to 1 (idle line level), watchdog counter 0.
REQ-024 RESET asserted mid-frame SHALL discard the frame without frame_done; first frame after reset requires a fresh load pulse.

Configuration
REQ-025 Macro DB15_JOY_TX_WATCHDOG_EN defined: SHALL count clk_sys cycles since last load falling edge, saturating at WD_CYCLES; link_active = 1 while count < WD_CYCLES and at least one load seen since reset, else 0; when 0, joy_data_o SHALL be forced 1.
REQ-026 Macro undefined: SHALL omit the counter; link_active tied to 1; joy_data_o per REQ-015..020 only.

Structure
REQ-027 Package db15_pkg SHALL hold FRAME_BITS = 32, PLAYER_BITS = 16, and the state enum type db15_state_t.
REQ-028 Sub-module db15_sync SHALL implement one synchronizer plus rise/fall pulse outputs, instantiated twice.

Verification
REQ-029 joystick1 = 16'h0001, joystick2 = 16'h8000, load pulse then 32 clk edges -> serial stream 1x15,0, then 0,1x15; frame_done one pulse after edge 32; bit_count = 32.
REQ-030 Change joystick1 from 0 to 16'hFFFF after load rises, before first clk edge -> frame shifts all ones for player 1 (old value).
REQ-031 Load pulse after 10 clk edges -> bit_count = 0, no frame_done, next frame restarts at joystick1[15].
REQ-032 40 clk edges after one load -> edges 33..40 give joy_data_o = 1, bit_count stays 32, single frame_done.
REQ-033 Watchdog enabled, WD_CYCLES = 100, load stops for 100 cycles -> link_active falls, joy_data_o = 1; next load -> link_active = 1 within SYNC_STAGES+2 cycles.
REQ-034 RESET at edge 16 of a frame -> all outputs at reset values next cycle; clk edges before next load leave joy_data_o = 1.
